pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Produces enable and flush strobes for the PC, F/D, D/E, E/M and M/W registers.
- Resolves load-use hazards, taken branches/jumps and data-memory wait states.
- Sequences halt: once a halt reaches EX, older instructions drain, then the core stops.

Parameters:
DRAIN_CYCLES, 2, cycles after halt acceptance before halted asserts (E/M and M/W retire)
MEM_TIMEOUT, 255, max consecutive mem-wait cycles before mem_err sets
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low reset
id_rs1_index  in  5  rs1 of instruction in ID
id_rs2_index  in  5  rs2 of instruction in ID
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
ex_rd_index  in  5  rd of instruction in EX (D/E register output)
ex_is_load  in  1  EX instruction is a load (D/E wb_sel)
ex_branch_taken  in  1  EX resolved taken branch/jump
ex_halt  in  1  D/E halt bit
mem_req  in  1  MEM stage has an active data-memory access
mem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC register update enable
fd_en  out  1  F/D register load enable
fd_flush  out  1  F/D load NOP (wins over fd_en)
de_en  out  1  D/E register load enable
de_flush  out  1  D/E load zeros/bubble (wins over de_en)
em_en  out  1  E/M register load enable
mw_en  out  1  M/W register load enable
halted  out  1  core stopped
mem_err  out  1  sticky memory timeout flag
stall_cnt  out  CNT_W  saturating count of stall cycles
flush_cnt  out  CNT_W  saturating count of branch flushes

Behaviour:
- Reset: all state updates on the clk edge with rst==0.
  - State goes to RUN; wait and drain counters, mem_err, stall_cnt and flush_cnt clear.
  - Combinationally, while rst==0: every enable and flush output is 0 and halted is 0.
- FSM states: RUN, MEM_WAIT, DRAIN, HALTED. Outputs are combinational from state plus inputs, so stalls take effect in the same cycle.
- Hazard signals:
  - memstall = mem_req & ~mem_ready.
  - loaduse = ex_is_load & (ex_rd_index!=0) & ((id_rs1_used & id_rs1_index==ex_rd_index) | (id_rs2_used & id_rs2_index==ex_rd_index)).
- Default (no event): all enables 1, both flushes 0.
- Priority in RUN/MEM_WAIT is memstall > ex_halt > ex_branch_taken > loaduse.
  - memstall: all enables 0, flushes 0. Next state is MEM_WAIT; wait counter increments.
  - ex_halt: pc_en=0, fd_flush=1, de_flush=1, em_en=mw_en=1. Next state is DRAIN; drain counter loads DRAIN_CYCLES-1.
  - branch: pc_en=1, fd_flush=1, de_flush=1, em_en=mw_en=1; flush_cnt increments. The branch overrides a simultaneous loaduse.
  - loaduse: pc_en=0, fd_en=0, de_flush=1, em_en=mw_en=1 (one bubble per cycle while the condition holds).
- MEM_WAIT:
  - Returns to RUN on the cycle memstall drops; that cycle's event is evaluated with RUN rules.
  - The wait counter clears on exit.
  - When the wait counter reaches MEM_TIMEOUT, mem_err sets. It remains set until reset; the stall continues.
- DRAIN:
  - pc_en=0, fd_en=0, de_flush=1, em_en=mw_en=1.
  - Branch and loaduse are ignored.
  - memstall freezes all enables and the drain counter.
  - When the counter reaches 0 on a non-stalled cycle, next state is HALTED.
- HALTED: all enables 0, flushes 0, halted=1. The block leaves HALTED only through reset.
- stall_cnt increments on every cycle in RUN or MEM_WAIT where pc_en==0 due to memstall or loaduse.
- Both counters saturate at 2^CNT_W-1 and do not wrap.
- Reset mid-drain or mid-wait aborts the sequence and returns to RUN on the next edge.

Test Plan:
1. Load x5 in EX, ID uses rs1=5 -> one cycle with pc_en=0, fd_en=0, de_flush=1; stall_cnt=1. Repeat with rd=0 -> no stall.
2. ex_branch_taken=1 together with loaduse true -> fd_flush=1, de_flush=1, pc_en=1; flush_cnt=1; stall_cnt unchanged.
3. mem_req=1, mem_ready=0 for 3 cycles, then ready -> all enables 0 for 3 cycles, state returns to RUN, stall_cnt=3.
4. ex_halt=1 -> DRAIN; with DRAIN_CYCLES=2, halted=1 on the 3rd edge after acceptance. A memstall injected mid-drain delays halted by the stall length.
5. MEM_TIMEOUT=4, ready never asserted -> mem_err=1 after 4 wait cycles and stays 1. Pulsing rst=0 for one edge clears mem_err, counters and state.
6. Hold loaduse for 2^CNT_W+3 cycles with CNT_W=4 -> stall_cnt stays at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for a 5-stage pipeline.
// Handles load-use, taken branches, memory wait states and halt drain.
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_index,
    input  logic [4:0]       id_rs2_index,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd_index,
    input  logic             ex_is_load,
    input  logic             ex_branch_taken,
    input  logic             ex_halt,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             fd_en,
    output logic             fd_flush,
    output logic             de_en,
    output logic             de_flush,
    output logic             em_en,
    output logic             mw_en,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;
    state_t state, state_n;
    logic [WW-1:0] wait_cnt, wait_n;
    logic [DW-1:0] drain_cnt, drain_n;
    logic memstall, loaduse, stall_inc, flush_inc, err_set;
    assign memstall = mem_req & ~mem_ready;
    assign loaduse  = ex_is_load & (ex_rd_index != 5'd0) &
                      ((id_rs1_used & (id_rs1_index == ex_rd_index)) |
                       (id_rs2_used & (id_rs2_index == ex_rd_index)));
    always_comb begin
        {pc_en, fd_en, de_en, em_en, mw_en} = '1;
        {fd_flush, de_flush, halted} = '0;
        state_n   = state;
        wait_n    = '0;
        drain_n   = drain_cnt;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        err_set   = 1'b0;
        case (state)
            RUN, MEM_WAIT: begin
                if (memstall) begin
                    {pc_en, fd_en, de_en, em_en, mw_en} = '0;
                    state_n   = MEM_WAIT;
                    wait_n    = (wait_cnt == WW'(MEM_TIMEOUT)) ? wait_cnt : wait_cnt + WW'(1);
                    err_set   = (wait_n == WW'(MEM_TIMEOUT));
                    stall_inc = 1'b1;
                end else if (ex_halt) begin
                    pc_en    = 1'b0;
                    fd_flush = 1'b1;
                    de_flush = 1'b1;
                    state_n  = DRAIN;
                    drain_n  = DW'(DRAIN_CYCLES - 1);
                end else if (ex_branch_taken) begin
                    fd_flush  = 1'b1;
                    de_flush  = 1'b1;
                    flush_inc = 1'b1;
                    state_n   = RUN;
                end else if (loaduse) begin
                    pc_en     = 1'b0;
                    fd_en     = 1'b0;
                    de_flush  = 1'b1;
                    stall_inc = 1'b1;
                    state_n   = RUN;
                end else begin
                    state_n = RUN;
                end
            end
            DRAIN: begin
                if (memstall) begin
                    {pc_en, fd_en, de_en, em_en, mw_en} = '0;
                end else begin
                    pc_en    = 1'b0;
                    fd_en    = 1'b0;
                    de_flush = 1'b1;
                    drain_n  = (drain_cnt == '0) ? drain_cnt : drain_cnt - DW'(1);
                    state_n  = (drain_cnt == '0) ? HALTED : DRAIN;
                end
            end
            default: begin
                {pc_en, fd_en, de_en, em_en, mw_en} = '0;
                halted = 1'b1;
            end
        endcase
        // Reset forces the pipeline frozen regardless of state
        if (!rst) begin
            {pc_en, fd_en, de_en, em_en, mw_en} = '0;
            {fd_flush, de_flush, halted} = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            drain_cnt <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_n;
            drain_cnt <= drain_n;
            mem_err   <= mem_err | err_set;
            stall_cnt <= (stall_inc && stall_cnt != '1) ? stall_cnt + CNT_W'(1) : stall_cnt;
            flush_cnt <= (flush_inc && flush_cnt != '1) ? flush_cnt + CNT_W'(1) : flush_cnt;
        end
    end
endmodule
